mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NCH, default 2: number of requesting channels (cores/caches), range 2..8.
REQ-002 Parameter WORD_W, default 32: data and address width in bits.
REQ-003 Parameter TIMEOUT, default 255: maximum BUSY cycles before forced error, range 1..65535.
REQ-004 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with channel 0 highest.
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 RST  in  1  reset, synchronous and active-high.
REQ-007 ren  in  NCH  per-channel read request.
REQ-008 wen  in  NCH  per-channel write request.
REQ-009 addr  in  NCH*WORD_W  per-channel byte address; channel i occupies bits [i*WORD_W +: WORD_W].
REQ-010 store  in  NCH*WORD_W  per-channel write data, packed the same way as addr.
REQ-011 wait_o  out  NCH  per-channel stall; high while that channel's request is unserviced.
REQ-012 load  out  WORD_W  read data, broadcast to all channels.
REQ-013 err  out  NCH  per-channel one-cycle error pulse.
REQ-014 ramREN, ramWEN  out  1 each  memory read and write strobes.
REQ-015 ramaddr, ramstore  out  WORD_W each  memory address and write data.
REQ-016 ramload  in  WORD_W  memory read data.
REQ-017 ramstate  in  2  memory status, ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-018 The block SHALL define req[i] = ren[i] | wen[i]; when both are high, the access SHALL be a write.
REQ-019 The FSM SHALL have two states: IDLE and BUSY.
REQ-020 IDLE, any req: the block SHALL select winner g, register g, clear the timeout counter, and enter BUSY on the next edge; no RAM strobe SHALL be driven in IDLE.
REQ-021 With RR_EN=1, the search SHALL start at (last+1) mod NCH and wrap; with RR_EN=0, the lowest requesting index SHALL win.
REQ-022 BUSY: ramaddr/ramstore SHALL equal addr[g]/store[g]; ramWEN = wen[g]; ramREN = ren[g] & ~wen[g]; all combinational from the current channel-g inputs.
REQ-023 BUSY with ramstate==ACCESS: in that cycle wait_o[g]=0 and load=ramload; last<=g; next state IDLE.
REQ-024 BUSY with ramstate==ERROR: in that cycle err[g]=1 and wait_o[g]=0; last<=g; next state IDLE.
REQ-025 BUSY, counter reaching TIMEOUT without ACCESS/ERROR: treated as ERROR (REQ-024 behaviour) in that cycle.
REQ-026 BUSY, counter: increments each BUSY cycle, saturating, width ceil(log2(TIMEOUT+1)).
REQ-027 BUSY with req[g]==0 (requester withdrew): RAM strobes SHALL be low that cycle; next state IDLE; last unchanged; no err.
REQ-028 For every i not completed this cycle, wait_o[i] = req[i].
REQ-029 load SHALL be 0 except in ACCESS-completion cycles.
REQ-030 A channel that completes SHALL NOT be re-granted before the following IDLE cycle, giving at most one access per two cycles per channel.
REQ-031 With RR_EN=1 and all NCH requesting continuously, grants SHALL rotate 0,1,...,NCH-1,0 with no starvation.
REQ-032 Changes to addr[g]/store[g] during BUSY SHALL pass through to the RAM; the requester holds them stable while wait_o is high.

Reset
REQ-033 RST high at an edge: state<=IDLE, g<=0, last<=NCH-1, counter<=0; this SHALL take priority over any in-flight access.
REQ-034 During and after reset: ramREN=ramWEN=0, ramaddr=ramstore=0, load=0, err=0, wait_o=req.

Verification
REQ-035 NCH=2, RR_EN=1: ch0 read at 0x40, RAM gives ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF -> wait_o[0] low exactly in the 4th post-grant cycle, load=0xDEADBEEF; ch1 untouched.
REQ-036 NCH=4, RR_EN=1: all channels request continuously, ACCESS on first BUSY cycle -> grant order 0,1,2,3,0, one completion every 2 cycles.
REQ-037 ch1 asserts ren and wen together at 0x80 with store=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
REQ-038 TIMEOUT=4, ramstate held BUSY -> err[g] pulses for one cycle on the 4th BUSY cycle, then FSM returns to IDLE.
REQ-039 ramstate=ERROR on ch0 write -> err[0]=1 for one cycle, wait_o[0]=0, no load change; a subsequent ch0 retry is serviced normally.
REQ-040 RST asserted mid-BUSY -> next cycle strobes low, IDLE; with RR_EN=1 and ch0, ch1 both requesting, ch0 wins first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port among NCH requesting channels.
// A two-state FSM grants one channel at a time. In BUSY it forwards that
// channel's request to the RAM until the RAM reports ACCESS or ERROR, the
// request is withdrawn, or the access times out.
module mem_arbiter #(
  parameter int NCH     = 2,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int RR_EN   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NCH-1:0]        ren,
  input  logic [NCH-1:0]        wen,
  input  logic [NCH*WORD_W-1:0] addr,
  input  logic [NCH*WORD_W-1:0] store,
  output logic [NCH-1:0]        wait_o,
  output logic [WORD_W-1:0]     load,
  output logic [NCH-1:0]        err,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [WORD_W-1:0]     ramaddr,
  output logic [WORD_W-1:0]     ramstore,
  input  logic [WORD_W-1:0]     ramload,
  input  logic [1:0]            ramstate
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   last;
  logic [CW-1:0]   cnt;

  logic [NCH-1:0]  req;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic            found;
  logic            timed_out;
  logic            done;

  // A write takes precedence when a channel raises both strobes.
  assign req       = ren | wen;
  assign timed_out = (cnt >= CW'(TIMEOUT - 1));

  // Winner search: round-robin starting after the last completed channel,
  // or plain lowest-index-first when round-robin is disabled.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (RR_EN != 0) begin
        idx = IW'((int'(last) + 1 + k) % NCH);
      end else begin
        idx = IW'(k);
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and output decode; reset forces every output to its idle value.
  always_comb begin
    state_next = state;
    wait_o     = req;
    load       = '0;
    err        = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    done       = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (|req) begin
            state_next = BUSY;
          end
        end
        BUSY: begin
          ramaddr  = addr[int'(gnt)*WORD_W +: WORD_W];
          ramstore = store[int'(gnt)*WORD_W +: WORD_W];
          if (!req[gnt]) begin
            state_next = IDLE;
          end else begin
            ramWEN = wen[gnt];
            ramREN = ren[gnt] & ~wen[gnt];
            if (ramstate == RAM_ACCESS) begin
              wait_o[gnt] = 1'b0;
              load        = ramload;
              done        = 1'b1;
              state_next  = IDLE;
            end else if ((ramstate == RAM_ERROR) || timed_out) begin
              wait_o[gnt] = 1'b0;
              err[gnt]    = 1'b1;
              done        = 1'b1;
              state_next  = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, grant, round-robin pointer and timeout counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= IW'(NCH - 1);
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        cnt <= '0;
        if (|req) begin
          gnt <= pick;
        end
      end else begin
        if (cnt != CW'(TIMEOUT)) begin
          cnt <= cnt + 1'b1;
        end
        if (done) begin
          last <= gnt;
        end
      end
    end
  end

endmodule
